// File: rtl/guess_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | guess_judge: number-guessing game control (debounced buttons, BCD judge)   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module guess_judge #(
  parameter int DB_CYCLES = 250000,
  parameter int MAX_TRIES = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] TGT_10,
  input  logic [3:0] TGT_1,
  input  logic       BTN_OK,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  output logic [3:0] DISP_10,
  output logic [3:0] DISP_1,
  output logic [3:0] TRY_10,
  output logic [3:0] TRY_1,
  output logic [1:0] RES,
  output logic       WIN,
  output logic       LOSE
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTER = 3'd1,
    S_JUDGE = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  logic [2:0] w_btn_raw;
  logic [2:0] w_pulse;

  assign w_btn_raw = {BTN_DN, BTN_UP, BTN_OK};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_btn
      logic [1:0]    r_sync;
      logic          r_level;
      logic [CW-1:0] r_cnt;
      logic          r_pulse;

      // Accepted level follows the synchronized input only after it has
      // disagreed for DB_CYCLES straight cycles; the pulse marks a 0->1 accept.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          r_sync  <= 2'b00;
          r_level <= 1'b0;
          r_cnt   <= '0;
          r_pulse <= 1'b0;
        end else begin
          r_sync  <= {r_sync[0], w_btn_raw[i]};
          r_pulse <= 1'b0;
          if (r_sync[1] != r_level) begin
            if (r_cnt == CW'(DB_CYCLES - 1)) begin
              r_level <= r_sync[1];
              r_cnt   <= '0;
              r_pulse <= r_sync[1];
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_pulse[i] = r_pulse;
    end
  endgenerate

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] hi, lo;
    hi = v[7:4];
    lo = v[3:0] + 4'd1;
    if (v[3:0] == 4'd9) begin
      lo = 4'd0;
      hi = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end
    return {hi, lo};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] hi, lo;
    hi = v[7:4];
    lo = v[3:0] - 4'd1;
    if (v[3:0] == 4'd0) begin
      lo = 4'd9;
      hi = (v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1;
    end
    return {hi, lo};
  endfunction

  function automatic logic [6:0] bcd_bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  state_t     r_state;
  logic [7:0] r_guess;
  logic [7:0] r_try;
  logic [7:0] r_tgt;
  logic [1:0] r_res;
  logic       r_win;
  logic       r_lose;

  logic       w_ok, w_up, w_dn;
  logic [7:0] w_try_nxt;
  logic [6:0] w_guess_bin, w_tgt_bin;

  assign w_ok        = w_pulse[0];
  assign w_up        = w_pulse[1] & ~w_pulse[0];
  assign w_dn        = w_pulse[2] & ~w_pulse[1] & ~w_pulse[0];
  assign w_try_nxt   = (r_try == 8'h99) ? 8'h99 : bcd_inc(r_try);
  assign w_guess_bin = bcd_bin(r_guess);
  assign w_tgt_bin   = bcd_bin(r_tgt);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_guess <= 8'h50;
      r_try   <= 8'h00;
      r_tgt   <= 8'h00;
      r_res   <= 2'b00;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ok) begin
            r_tgt   <= {(TGT_10 > 4'd9) ? 4'd9 : TGT_10,
                        (TGT_1  > 4'd9) ? 4'd9 : TGT_1};
            r_guess <= 8'h50;
            r_try   <= 8'h00;
            r_res   <= 2'b00;
            r_state <= S_ENTER;
          end
        end
        S_ENTER: begin
          if (w_ok)      r_state <= S_JUDGE;
          else if (w_up) r_guess <= bcd_inc(r_guess);
          else if (w_dn) r_guess <= bcd_dec(r_guess);
        end
        S_JUDGE: begin
          r_try <= w_try_nxt;
          if (w_guess_bin < w_tgt_bin)      r_res <= 2'b01;
          else if (w_guess_bin > w_tgt_bin) r_res <= 2'b10;
          else                              r_res <= 2'b11;
          if (w_guess_bin == w_tgt_bin) begin
            r_state <= S_WIN;
            r_win   <= 1'b1;
          end else if (bcd_bin(w_try_nxt) == 7'(MAX_TRIES)) begin
            r_state <= S_LOSE;
            r_lose  <= 1'b1;
          end else begin
            r_state <= S_ENTER;
          end
        end
        S_WIN, S_LOSE: begin
          if (w_ok) begin
            r_state <= S_IDLE;
            r_guess <= 8'h50;
            r_try   <= 8'h00;
            r_res   <= 2'b00;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DISP_10 = r_guess[7:4];
  assign DISP_1  = r_guess[3:0];
  assign TRY_10  = r_try[7:4];
  assign TRY_1   = r_try[3:0];
  assign RES     = r_res;
  assign WIN     = r_win;
  assign LOSE    = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_guess_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_guess_judge: scoreboard bench for guess_judge (DB_CYCLES=4, 3 tries)    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_guess_judge;

  localparam int MAXT = 3;
  localparam int M_IDLE = 0, M_ENTER = 1, M_WIN = 2, M_LOSE = 3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] TGT_10 = 4'd0, TGT_1 = 4'd0;
  logic       BTN_OK = 1'b0, BTN_UP = 1'b0, BTN_DN = 1'b0;
  logic [3:0] DISP_10, DISP_1, TRY_10, TRY_1;
  logic [1:0] RES;
  logic       WIN, LOSE;

  guess_judge #(.DB_CYCLES(4), .MAX_TRIES(MAXT)) dut (
    .CLK(CLK), .RESET(RESET), .TGT_10(TGT_10), .TGT_1(TGT_1),
    .BTN_OK(BTN_OK), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN),
    .DISP_10(DISP_10), .DISP_1(DISP_1), .TRY_10(TRY_10), .TRY_1(TRY_1),
    .RES(RES), .WIN(WIN), .LOSE(LOSE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] dut_vec;
  assign dut_vec = {DISP_10, DISP_1, TRY_10, TRY_1, RES, WIN, LOSE};

  int m_guess, m_try, m_res, m_tgt, m_st;
  bit m_win, m_lose;

  function automatic logic [19:0] model_vec();
    return {4'(m_guess / 10), 4'(m_guess % 10), 4'(m_try / 10), 4'(m_try % 10),
            2'(m_res), m_win, m_lose};
  endfunction

  task automatic check_eq(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_eq(tag, dut_vec, exp_q.pop_front());
    end
  endtask

  task automatic model_reset();
    m_guess = 50; m_try = 0; m_res = 0; m_tgt = 0; m_st = M_IDLE;
    m_win = 0; m_lose = 0;
  endtask

  task automatic model_ok();
    case (m_st)
      M_IDLE: begin
        m_tgt = ((TGT_10 > 9) ? 9 : int'(TGT_10)) * 10 + ((TGT_1 > 9) ? 9 : int'(TGT_1));
        m_guess = 50; m_try = 0; m_res = 0; m_st = M_ENTER;
      end
      M_ENTER: begin
        if (m_try < 99) m_try++;
        m_res = (m_guess < m_tgt) ? 1 : (m_guess > m_tgt) ? 2 : 3;
        if (m_res == 3) begin m_st = M_WIN; m_win = 1; end
        else if (m_try == MAXT) begin m_st = M_LOSE; m_lose = 1; end
      end
      default: begin
        m_st = M_IDLE; m_guess = 50; m_try = 0; m_res = 0; m_win = 0; m_lose = 0;
      end
    endcase
  endtask

  // which: 0 OK, 1 UP, 2 DN, 3 OK+UP together
  task automatic press(input int which, input string tag);
    if (which == 0 || which == 3) model_ok();
    else if (m_st == M_ENTER) m_guess = (which == 1) ? (m_guess + 1) % 100 : (m_guess + 99) % 100;
    exp_q.push_back(model_vec());
    @(negedge CLK);
    BTN_OK = (which == 0 || which == 3);
    BTN_UP = (which == 1 || which == 3);
    BTN_DN = (which == 2);
    repeat (10) @(negedge CLK);
    BTN_OK = 1'b0; BTN_UP = 1'b0; BTN_DN = 1'b0;
    repeat (10) @(negedge CLK);
    pop_check(tag);
  endtask

  initial begin
    model_reset();
    exp_q.push_back(model_vec());
    repeat (3) @(negedge CLK);
    pop_check("reset");
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    TGT_10 = 4'd7; TGT_1 = 4'd3;
    press(0, "start");
    TGT_10 = 4'd1; TGT_1 = 4'd1;
    for (int i = 0; i < 27; i++) press(1, $sformatf("up%0d", i));
    press(0, "judge_high");
    for (int i = 0; i < 4; i++) press(2, $sformatf("dn%0d", i));
    press(0, "judge_eq");
    press(1, "win_hold");

    TGT_10 = 4'd0; TGT_1 = 4'd0;
    press(0, "win_exit");
    press(0, "start2");
    for (int i = 0; i < 50; i++) press(2, $sformatf("walk_dn%0d", i));
    press(2, "wrap_dn");
    press(1, "wrap_up");

    // Bouncy press: 2-cycle toggles never satisfy the debounce window.
    m_guess = (m_guess + 1) % 100;
    exp_q.push_back(model_vec());
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); BTN_UP = ~BTN_UP;
      @(negedge CLK);
    end
    BTN_UP = 1'b1;
    repeat (10) @(negedge CLK);
    BTN_UP = 1'b0;
    repeat (10) @(negedge CLK);
    pop_check("bounce");

    m_guess = (m_guess + 1) % 100;
    exp_q.push_back(model_vec());
    BTN_UP = 1'b1;
    repeat (100) @(negedge CLK);
    BTN_UP = 1'b0;
    repeat (10) @(negedge CLK);
    pop_check("held");

    press(1, "pre_reset");
    @(posedge CLK);
    #2 RESET = 1'b0;
    model_reset();
    exp_q.push_back(model_vec());
    #1 pop_check("async_reset");
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    press(0, "start3");
    press(3, "ok_up");
    press(0, "try2");
    press(0, "try3_lose");
    press(1, "lose_hold");
    press(0, "lose_exit");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/guess_judge.md
Name: guess_judge

Overview:
- Game-control stage that sits directly downstream of the two-digit random generator.
- Consumes the generator's BCD tens/ones value as a hidden target and lets the player step a two-digit BCD guess up and down with push buttons.
- On each guess submission it judges the guess as low, high or equal against the target, counts attempts, and declares a win or loss.
- Its guess and attempt digits feed the two-digit 7-segment scan stage.

Parameters:
- DB_CYCLES, 250000, consecutive stable cycles required before a raw button level is accepted. Benches use 4.
- MAX_TRIES, 10, attempts allowed (1..99). The game is lost when the count reaches this value without a match.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset (asserted at 0).
- TGT_10  input  4  target tens digit (BCD) from the random generator.
- TGT_1  input  4  target ones digit (BCD) from the random generator.
- BTN_OK  input  1  raw push button, active-high, asynchronous to CLK.
- BTN_UP  input  1  raw push button, active-high.
- BTN_DN  input  1  raw push button, active-high.
- DISP_10  output  4  current guess, tens digit (BCD).
- DISP_1  output  4  current guess, ones digit (BCD).
- TRY_10  output  4  attempt count, tens digit (BCD).
- TRY_1  output  4  attempt count, ones digit (BCD).
- RES  output  2  last judgement: 00 none, 01 guess<target, 10 guess>target, 11 equal.
- WIN  output  1  high while in WIN state.
- LOSE  output  1  high while in LOSE state.

Behaviour:
- Reset (RESET=0, async): state IDLE, guess 50 (DISP_10=5, DISP_1=0), TRY=00, RES=00, WIN=0, LOSE=0, target registers 0, debounce counters and synchronizers cleared.
- Button front end (per button):
  - Two-flop synchronizer, then a debounce counter.
  - The accepted level changes only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
  - A rising edge of the accepted level produces a one-cycle pulse.
  - A held button yields exactly one pulse; no auto-repeat.
- Same-cycle pulses: priority OK > UP > DN. Lower-priority pulses in that cycle are discarded.
- FSM states: IDLE, ENTER, JUDGE, WIN, LOSE.
- IDLE:
  - OK pulse → capture TGT_10/TGT_1 into target registers; any digit >9 is stored as 9.
  - Also on that pulse: guess=50, TRY=00, RES=00; go to ENTER.
  - UP/DN ignored.
- ENTER:
  - UP pulse → guess+1 in BCD; 99 wraps to 00.
  - DN pulse → guess−1; 00 wraps to 99.
  - Display updates the cycle after the pulse.
  - OK pulse → go to JUDGE.
- JUDGE (exactly one cycle):
  - TRY increments in BCD, saturating at 99.
  - RES is set by comparing binary values 10·tens+ones.
  - Next state, evaluated using the incremented TRY:
    - equal → WIN;
    - else TRY==MAX_TRIES → LOSE;
    - else → ENTER.
- Latency: OK pulse at edge n → JUDGE active after edge n+1 → RES/TRY/WIN/LOSE valid after edge n+2. A button edge adds 2 synchronizer cycles plus DB_CYCLES before the pulse.
- Buttons during JUDGE: all pulses arriving during JUDGE are discarded.
- WIN/LOSE:
  - Guess, TRY and RES are held.
  - UP/DN ignored.
  - OK pulse → IDLE with guess=50, TRY=00, RES=00, WIN=LOSE=0.
- Target stability: the target is sampled only at the IDLE→ENTER transition; TGT changes afterwards have no effect.
- Reset mid-game: immediate return to the reset values above, regardless of state.

Test Plan:
- Reset, DB_CYCLES=4, TGT=7/3, OK pulse → ENTER, DISP=50, TRY=00; a later TGT change to 1/1 does not alter the judgement.
- In ENTER, 27 UP presses → DISP=77; OK → RES=10, TRY=01. Then 4 DN → 73; OK → RES=11, WIN=1, TRY=02; UP ignored, DISP stays 73.
- Wrap: guess 99 + UP → 00; 00 + DN → 99; TRY unchanged in both cases.
- Bounce: BTN_UP toggles every 2 cycles for 20 cycles, then holds high 10 cycles → exactly one increment. Held high 100 cycles → one increment only.
- MAX_TRIES=3, TGT=0/0, guess 50 submitted 3 times → RES=10 each time; after the third submission TRY=03, LOSE=1. OK → IDLE, DISP=50, TRY=00, RES=00.
- OK and UP rising in the same cycle in ENTER → JUDGE taken, guess unchanged. RESET=0 pulsed mid-ENTER → all outputs return to reset values asynchronously.
